uart_tx_serializer: RTL

UART transmit stage that buffers bytes in a 16-entry FIFO and serializes them as 8N1 frames: start bit, eight data bits LSB first, one stop bit. It sits between the byte producer and the serial pin, directly downstream of the TX baud generator. It drives that generator's enable and consumes its one-cycle bit tick. Frames in the FIFO go out back-to-back with no idle gap.

---
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter: a 16-entry byte FIFO feeding a tick-paced serializer.
// The baud generator is enabled for the whole burst, and consecutive frames are sent without an idle gap.
module uart_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iWR_en,
    input  logic [DATA_W-1:0] iWR_data,
    output logic              oFULL,
    output logic              oEMPTY,
    output logic [ADDR_W:0]   oLEVEL,
    output logic              oOVERFLOW,
    input  logic              iBAUD_tick,
    output logic              oTX_en,
    output logic              oTX,
    output logic              oBUSY
);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, STOP} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(FIFO_DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                tx_q, tx_d;
    logic                tx_en_q, tx_en_d;
    logic                full, empty, wr_accept, pop;
    logic [DATA_W-1:0]   head;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign wr_accept = iWR_en && !full;
    assign head      = mem_q[rd_ptr_q];

    // A write while full is dropped even when a pop happens in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (iWR_en & full);
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        tx_en_d   = tx_en_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                tx_en_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_en_d = 1'b1;
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (iBAUD_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (iBAUD_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (iBAUD_tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // The empty check uses the registered count, so a same-edge write waits for IDLE.
                if (iBAUD_tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        tx_en_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                tx_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            tx_en_q   <= tx_en_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= iWR_data;
        end
        shift_q <= shift_d;
    end

    assign oFULL     = full;
    assign oEMPTY    = empty;
    assign oLEVEL    = count_q;
    assign oOVERFLOW = ovf_q;
    assign oTX       = tx_q;
    assign oTX_en    = tx_en_q;
    assign oBUSY     = (state_q != IDLE);

endmodule
